// File: rtl/cpu_axi_bridge.sv
// Bridges the CPU fetch and data sram-like ports onto a single AXI3 master.
// One read FSM (AR/R) and one write FSM (AW/W/B); data side has priority.
module cpu_axi_bridge #(
    parameter logic [3:0] INST_ID = 4'd0,
    parameter logic [3:0] DATA_ID = 4'd1
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        inst_req,
    input  logic [1:0]  inst_size,
    input  logic [31:0] inst_addr,
    output logic        inst_addr_ok,
    output logic        inst_data_ok,
    output logic [31:0] inst_rdata,
    input  logic        data_req,
    input  logic        data_wr,
    input  logic [1:0]  data_size,
    input  logic [31:0] data_addr,
    input  logic [3:0]  data_wstrb,
    input  logic [31:0] data_wdata,
    output logic        data_addr_ok,
    output logic        data_data_ok,
    output logic [31:0] data_rdata,
    output logic [3:0]  arid,
    output logic [31:0] araddr,
    output logic [2:0]  arsize,
    output logic        arvalid,
    input  logic        arready,
    input  logic [3:0]  rid,
    input  logic [31:0] rdata,
    input  logic        rvalid,
    output logic        rready,
    output logic [3:0]  awid,
    output logic [31:0] awaddr,
    output logic [2:0]  awsize,
    output logic        awvalid,
    input  logic        awready,
    output logic [3:0]  wid,
    output logic [31:0] wdata,
    output logic [3:0]  wstrb,
    output logic        wvalid,
    input  logic        wready,
    input  logic        bvalid,
    output logic        bready
);

    typedef enum logic [1:0] {R_IDLE, R_AR, R_DATA} r_state_e;
    typedef enum logic [1:0] {W_IDLE, W_REQ, W_RESP} w_state_e;

    r_state_e    r_state_q, r_state_d;
    logic [31:0] ar_addr_q, ar_addr_d;
    logic [2:0]  ar_size_q, ar_size_d;
    logic [3:0]  ar_id_q, ar_id_d;
    logic        rd_owner_q, rd_owner_d;
    logic [31:0] inst_rdata_q, inst_rdata_d;
    logic [31:0] data_rdata_q, data_rdata_d;
    logic        inst_ok_q, inst_ok_d;
    logic        data_rd_ok_q, data_rd_ok_d;

    w_state_e    w_state_q, w_state_d;
    logic [31:0] aw_addr_q, aw_addr_d;
    logic [2:0]  aw_size_q, aw_size_d;
    logic [31:0] wdata_q, wdata_d;
    logic [3:0]  wstrb_q, wstrb_d;
    logic        aw_done_q, aw_done_d;
    logic        w_done_q, w_done_d;
    logic        data_wr_ok_q, data_wr_ok_d;

    logic r_idle, w_idle, data_rd_acc, data_wr_acc, inst_acc;
    logic aw_hs, w_hs;
    logic unused_rid;

    // Data accesses need both FSMs idle so reads and writes never reorder.
    assign r_idle      = (r_state_q == R_IDLE);
    assign w_idle      = (w_state_q == W_IDLE);
    assign data_rd_acc = resetn & data_req & ~data_wr & r_idle & w_idle;
    assign data_wr_acc = resetn & data_req &  data_wr & r_idle & w_idle;
    assign inst_acc    = resetn & inst_req & r_idle & ~data_rd_acc;

    assign inst_addr_ok = inst_acc;
    assign data_addr_ok = data_rd_acc | data_wr_acc;

    assign arvalid = (r_state_q == R_AR);
    assign rready  = (r_state_q == R_DATA);
    assign arid    = ar_id_q;
    assign araddr  = ar_addr_q;
    assign arsize  = ar_size_q;

    assign awvalid = (w_state_q == W_REQ) & ~aw_done_q;
    assign wvalid  = (w_state_q == W_REQ) & ~w_done_q;
    assign bready  = (w_state_q == W_RESP);
    assign awid    = DATA_ID;
    assign wid     = DATA_ID;
    assign awaddr  = aw_addr_q;
    assign awsize  = aw_size_q;
    assign wdata   = wdata_q;
    assign wstrb   = wstrb_q;
    assign aw_hs   = awvalid & awready;
    assign w_hs    = wvalid & wready;

    assign inst_data_ok = inst_ok_q;
    assign inst_rdata   = inst_rdata_q;
    assign data_data_ok = data_rd_ok_q | data_wr_ok_q;
    assign data_rdata   = data_rdata_q;

    // Read data is routed by the registered owner bit, not by rid.
    assign unused_rid = ^rid;

    always_comb begin
        r_state_d    = r_state_q;
        ar_addr_d    = ar_addr_q;
        ar_size_d    = ar_size_q;
        ar_id_d      = ar_id_q;
        rd_owner_d   = rd_owner_q;
        inst_rdata_d = inst_rdata_q;
        data_rdata_d = data_rdata_q;
        inst_ok_d    = 1'b0;
        data_rd_ok_d = 1'b0;
        case (r_state_q)
            R_IDLE: begin
                if (data_rd_acc) begin
                    r_state_d  = R_AR;
                    ar_addr_d  = data_addr;
                    ar_size_d  = {1'b0, data_size};
                    ar_id_d    = DATA_ID;
                    rd_owner_d = 1'b1;
                end else if (inst_acc) begin
                    r_state_d  = R_AR;
                    ar_addr_d  = inst_addr;
                    ar_size_d  = {1'b0, inst_size};
                    ar_id_d    = INST_ID;
                    rd_owner_d = 1'b0;
                end
            end
            R_AR: begin
                if (arready) r_state_d = R_DATA;
            end
            R_DATA: begin
                if (rvalid) begin
                    r_state_d = R_IDLE;
                    if (rd_owner_q) begin
                        data_rdata_d = rdata;
                        data_rd_ok_d = 1'b1;
                    end else begin
                        inst_rdata_d = rdata;
                        inst_ok_d    = 1'b1;
                    end
                end
            end
            default: r_state_d = R_IDLE;
        endcase
    end

    // AW and W complete independently; B is only accepted after both.
    always_comb begin
        w_state_d    = w_state_q;
        aw_addr_d    = aw_addr_q;
        aw_size_d    = aw_size_q;
        wdata_d      = wdata_q;
        wstrb_d      = wstrb_q;
        aw_done_d    = aw_done_q;
        w_done_d     = w_done_q;
        data_wr_ok_d = 1'b0;
        case (w_state_q)
            W_IDLE: begin
                if (data_wr_acc) begin
                    w_state_d = W_REQ;
                    aw_addr_d = data_addr;
                    aw_size_d = {1'b0, data_size};
                    wdata_d   = data_wdata;
                    wstrb_d   = data_wstrb;
                    aw_done_d = 1'b0;
                    w_done_d  = 1'b0;
                end
            end
            W_REQ: begin
                if ((aw_done_q | aw_hs) && (w_done_q | w_hs)) begin
                    w_state_d = W_RESP;
                    aw_done_d = 1'b0;
                    w_done_d  = 1'b0;
                end else begin
                    aw_done_d = aw_done_q | aw_hs;
                    w_done_d  = w_done_q | w_hs;
                end
            end
            W_RESP: begin
                if (bvalid) begin
                    w_state_d    = W_IDLE;
                    data_wr_ok_d = 1'b1;
                end
            end
            default: w_state_d = W_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_state_q    <= R_IDLE;
            ar_addr_q    <= '0;
            ar_size_q    <= '0;
            ar_id_q      <= '0;
            rd_owner_q   <= 1'b0;
            inst_rdata_q <= '0;
            data_rdata_q <= '0;
            inst_ok_q    <= 1'b0;
            data_rd_ok_q <= 1'b0;
            w_state_q    <= W_IDLE;
            aw_addr_q    <= '0;
            aw_size_q    <= '0;
            wdata_q      <= '0;
            wstrb_q      <= '0;
            aw_done_q    <= 1'b0;
            w_done_q     <= 1'b0;
            data_wr_ok_q <= 1'b0;
        end else begin
            r_state_q    <= r_state_d;
            ar_addr_q    <= ar_addr_d;
            ar_size_q    <= ar_size_d;
            ar_id_q      <= ar_id_d;
            rd_owner_q   <= rd_owner_d;
            inst_rdata_q <= inst_rdata_d;
            data_rdata_q <= data_rdata_d;
            inst_ok_q    <= inst_ok_d;
            data_rd_ok_q <= data_rd_ok_d;
            w_state_q    <= w_state_d;
            aw_addr_q    <= aw_addr_d;
            aw_size_q    <= aw_size_d;
            wdata_q      <= wdata_d;
            wstrb_q      <= wstrb_d;
            aw_done_q    <= aw_done_d;
            w_done_q     <= w_done_d;
            data_wr_ok_q <= data_wr_ok_d;
        end
    end

endmodule

// File: tb/tb_cpu_axi_bridge.sv
// Directed bench for cpu_axi_bridge: the bench plays the AXI slave cycle by cycle,
// and a scoreboard matches every data_ok pulse against queued expectations.
module tb_cpu_axi_bridge;

    logic        clk = 1'b0;
    logic        resetn;
    logic        inst_req;
    logic [1:0]  inst_size;
    logic [31:0] inst_addr;
    logic        inst_addr_ok, inst_data_ok;
    logic [31:0] inst_rdata;
    logic        data_req, data_wr;
    logic [1:0]  data_size;
    logic [31:0] data_addr;
    logic [3:0]  data_wstrb;
    logic [31:0] data_wdata;
    logic        data_addr_ok, data_data_ok;
    logic [31:0] data_rdata;
    logic [3:0]  arid;
    logic [31:0] araddr;
    logic [2:0]  arsize;
    logic        arvalid, arready;
    logic [3:0]  rid;
    logic [31:0] rdata;
    logic        rvalid, rready;
    logic [3:0]  awid;
    logic [31:0] awaddr;
    logic [2:0]  awsize;
    logic        awvalid, awready;
    logic [3:0]  wid;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        wvalid, wready;
    logic        bvalid, bready;

    typedef struct {
        bit          wr;
        logic [31:0] rdata;
    } dexp_t;

    logic [31:0] iq[$];
    dexp_t       dq[$];
    int          checks = 0;
    int          errors = 0;
    int          inst_ok_cnt = 0;
    int          data_ok_cnt = 0;
    int          base_i, base_d;

    cpu_axi_bridge #(.INST_ID(4'd0), .DATA_ID(4'd1)) dut (
        .clk(clk), .resetn(resetn),
        .inst_req(inst_req), .inst_size(inst_size), .inst_addr(inst_addr),
        .inst_addr_ok(inst_addr_ok), .inst_data_ok(inst_data_ok), .inst_rdata(inst_rdata),
        .data_req(data_req), .data_wr(data_wr), .data_size(data_size), .data_addr(data_addr),
        .data_wstrb(data_wstrb), .data_wdata(data_wdata),
        .data_addr_ok(data_addr_ok), .data_data_ok(data_data_ok), .data_rdata(data_rdata),
        .arid(arid), .araddr(araddr), .arsize(arsize), .arvalid(arvalid), .arready(arready),
        .rid(rid), .rdata(rdata), .rvalid(rvalid), .rready(rready),
        .awid(awid), .awaddr(awaddr), .awsize(awsize), .awvalid(awvalid), .awready(awready),
        .wid(wid), .wdata(wdata), .wstrb(wstrb), .wvalid(wvalid), .wready(wready),
        .bvalid(bvalid), .bready(bready)
    );

    always #5 clk = ~clk;

    task automatic chk1(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic sample();
        @(negedge clk);
        #1;
    endtask

    // Scoreboard: every data_ok pulse must match the oldest queued expectation.
    initial begin
        forever begin
            @(negedge clk);
            if (inst_data_ok) begin
                inst_ok_cnt++;
                chk1("inst_ok_expected", iq.size() > 0, 1'b1);
                if (iq.size() > 0) chk32("inst_rdata", inst_rdata, iq.pop_front());
            end
            if (data_data_ok) begin
                data_ok_cnt++;
                chk1("data_ok_expected", dq.size() > 0, 1'b1);
                if (dq.size() > 0) begin
                    dexp_t e;
                    e = dq.pop_front();
                    if (!e.wr) chk32("data_rdata", data_rdata, e.rdata);
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog simulation did not finish errors=%0d checks=%0d", errors, checks);
        $fatal(1, "watchdog");
    end

    initial begin
        resetn = 1'b0;
        inst_req = 1'b1; inst_size = 2'd2; inst_addr = 32'h1C000000;
        data_req = 1'b1; data_wr = 1'b0; data_size = 2'd2; data_addr = 32'h0;
        data_wstrb = 4'h0; data_wdata = 32'h0;
        arready = 1'b0; rid = 4'd0; rdata = 32'h0; rvalid = 1'b0;
        awready = 1'b0; wready = 1'b0; bvalid = 1'b0;

        // Reset state, with requests asserted to show acceptance is blocked
        tick(); tick();
        sample();
        chk1("rst_arvalid", arvalid, 1'b0);
        chk1("rst_rready", rready, 1'b0);
        chk1("rst_awvalid", awvalid, 1'b0);
        chk1("rst_wvalid", wvalid, 1'b0);
        chk1("rst_bready", bready, 1'b0);
        chk1("rst_inst_addr_ok", inst_addr_ok, 1'b0);
        chk1("rst_data_addr_ok", data_addr_ok, 1'b0);
        chk1("rst_inst_data_ok", inst_data_ok, 1'b0);
        chk1("rst_data_data_ok", data_data_ok, 1'b0);
        chk32("rst_araddr", araddr, 32'h0);
        chk32("rst_awaddr", awaddr, 32'h0);
        tick();
        resetn = 1'b1; inst_req = 1'b0; data_req = 1'b0;

        // Single fetch
        tick();
        inst_req = 1'b1; inst_addr = 32'h1C000000; inst_size = 2'd2; arready = 1'b1;
        sample();
        chk1("t1_inst_addr_ok", inst_addr_ok, 1'b1);
        chk1("t1_data_addr_ok", data_addr_ok, 1'b0);
        iq.push_back(32'h02800C0C);
        tick();
        inst_req = 1'b0;
        sample();
        chk1("t1_arvalid", arvalid, 1'b1);
        chk32("t1_araddr", araddr, 32'h1C000000);
        chk32("t1_arid", 32'(arid), 32'd0);
        chk32("t1_arsize", 32'(arsize), 32'd2);
        tick();
        rvalid = 1'b1; rdata = 32'h02800C0C; rid = 4'd0;
        sample();
        chk1("t1_rready", rready, 1'b1);
        chk1("t1_arvalid_low", arvalid, 1'b0);
        base_i = inst_ok_cnt;
        tick();
        rvalid = 1'b0;
        sample();
        chk1("t1_inst_data_ok", inst_data_ok, 1'b1);
        tick();
        sample();
        chk1("t1_inst_data_ok_drop", inst_data_ok, 1'b0);
        chk32("t1_ok_count", inst_ok_cnt, base_i + 1);

        // Simultaneous fetch and data read: data wins
        tick();
        inst_req = 1'b1; inst_addr = 32'h1C000004;
        data_req = 1'b1; data_wr = 1'b0; data_addr = 32'h1C0800F0; data_size = 2'd2;
        sample();
        chk1("t2_data_addr_ok", data_addr_ok, 1'b1);
        chk1("t2_inst_addr_ok", inst_addr_ok, 1'b0);
        dq.push_back('{wr: 1'b0, rdata: 32'h11223344});
        tick();
        data_req = 1'b0;
        sample();
        chk1("t2_arvalid", arvalid, 1'b1);
        chk32("t2_arid", 32'(arid), 32'd1);
        chk32("t2_araddr", araddr, 32'h1C0800F0);
        chk1("t2_inst_held_ar", inst_addr_ok, 1'b0);
        tick();
        rvalid = 1'b1; rdata = 32'h11223344; rid = 4'd1;
        sample();
        chk1("t2_inst_held_r", inst_addr_ok, 1'b0);
        tick();
        rvalid = 1'b0;
        sample();
        chk1("t2_data_data_ok", data_data_ok, 1'b1);
        chk1("t2_inst_addr_ok_after", inst_addr_ok, 1'b1);
        iq.push_back(32'hAAAA0001);
        tick();
        inst_req = 1'b0;
        sample();
        chk32("t2_fetch_arid", 32'(arid), 32'd0);
        chk32("t2_fetch_araddr", araddr, 32'h1C000004);
        tick();
        rvalid = 1'b1; rdata = 32'hAAAA0001; rid = 4'd0;
        tick();
        rvalid = 1'b0;
        sample();
        chk1("t2_fetch_data_ok", inst_data_ok, 1'b1);

        // Write then read same address: read held off until B accepted
        tick();
        data_req = 1'b1; data_wr = 1'b1; data_addr = 32'h1C080000; data_size = 2'd2;
        data_wstrb = 4'hF; data_wdata = 32'hDEADBEEF; awready = 1'b1; wready = 1'b1;
        sample();
        chk1("t3_wr_addr_ok", data_addr_ok, 1'b1);
        dq.push_back('{wr: 1'b1, rdata: 32'h0});
        base_d = data_ok_cnt;
        tick();
        data_wr = 1'b0;
        sample();
        chk1("t3_awvalid", awvalid, 1'b1);
        chk1("t3_wvalid", wvalid, 1'b1);
        chk32("t3_awaddr", awaddr, 32'h1C080000);
        chk32("t3_wdata", wdata, 32'hDEADBEEF);
        chk32("t3_wstrb", 32'(wstrb), 32'hF);
        chk32("t3_awid_wid", 32'({awid, wid}), 32'h11);
        chk1("t3_rd_blocked_req", data_addr_ok, 1'b0);
        tick();
        bvalid = 1'b1;
        sample();
        chk1("t3_bready", bready, 1'b1);
        chk1("t3_aw_w_low", awvalid | wvalid, 1'b0);
        chk1("t3_rd_blocked_resp", data_addr_ok, 1'b0);
        tick();
        bvalid = 1'b0;
        sample();
        chk1("t3_wr_data_ok", data_data_ok, 1'b1);
        chk1("t3_rd_addr_ok", data_addr_ok, 1'b1);
        dq.push_back('{wr: 1'b0, rdata: 32'hDEADBEEF});
        tick();
        data_req = 1'b0;
        sample();
        chk32("t3_rd_araddr", araddr, 32'h1C080000);
        tick();
        rvalid = 1'b1; rdata = 32'hDEADBEEF; rid = 4'd1;
        tick();
        rvalid = 1'b0;
        sample();
        chk32("t3_ok_count", data_ok_cnt, base_d + 2);

        // Split AW/W handshakes
        tick();
        data_req = 1'b1; data_wr = 1'b1; data_addr = 32'h1C080010; data_size = 2'd1;
        data_wstrb = 4'h3; data_wdata = 32'h12345678; awready = 1'b0; wready = 1'b0;
        sample();
        chk1("t4_addr_ok", data_addr_ok, 1'b1);
        dq.push_back('{wr: 1'b1, rdata: 32'h0});
        base_d = data_ok_cnt;
        tick();
        data_req = 1'b0; awready = 1'b1;
        sample();
        chk1("t4_c1_awvalid", awvalid, 1'b1);
        chk32("t4_awsize", 32'(awsize), 32'd1);
        tick();
        awready = 1'b0;
        sample();
        chk1("t4_c2_awvalid", awvalid, 1'b0);
        chk1("t4_c2_wvalid", wvalid, 1'b1);
        chk1("t4_c2_bready", bready, 1'b0);
        tick();
        sample();
        chk1("t4_c3_wvalid", wvalid, 1'b1);
        chk1("t4_c3_bready", bready, 1'b0);
        tick();
        wready = 1'b1;
        sample();
        chk1("t4_c4_wvalid", wvalid, 1'b1);
        chk32("t4_c4_wdata", wdata, 32'h12345678);
        tick();
        wready = 1'b0; bvalid = 1'b1;
        sample();
        chk1("t4_c5_wvalid", wvalid, 1'b0);
        chk1("t4_c5_bready", bready, 1'b1);
        tick();
        bvalid = 1'b0;
        tick(); tick();
        sample();
        chk32("t4_ok_count", data_ok_cnt, base_d + 1);

        // AR backpressure keeps arvalid/araddr stable
        tick();
        inst_req = 1'b1; inst_addr = 32'h1C000040; inst_size = 2'd2; arready = 1'b0;
        sample();
        chk1("t5_addr_ok", inst_addr_ok, 1'b1);
        iq.push_back(32'h0BADF00D);
        tick();
        inst_req = 1'b0; inst_addr = 32'hFFFFFFFF;
        for (int i = 0; i < 5; i++) begin
            sample();
            chk1("t5_arvalid_hold", arvalid, 1'b1);
            chk32("t5_araddr_hold", araddr, 32'h1C000040);
            tick();
        end
        arready = 1'b1;
        tick();
        rvalid = 1'b1; rdata = 32'h0BADF00D; rid = 4'd0;
        tick();
        rvalid = 1'b0;
        sample();
        chk1("t5_data_ok", inst_data_ok, 1'b1);

        // Fetch overlapping an outstanding write completes before B
        tick();
        data_req = 1'b1; data_wr = 1'b1; data_addr = 32'h1C080020; data_size = 2'd2;
        data_wstrb = 4'hF; data_wdata = 32'hCAFEF00D; awready = 1'b1; wready = 1'b1;
        sample();
        chk1("t5o_wr_addr_ok", data_addr_ok, 1'b1);
        dq.push_back('{wr: 1'b1, rdata: 32'h0});
        base_d = data_ok_cnt;
        base_i = inst_ok_cnt;
        tick();
        data_req = 1'b0;
        inst_req = 1'b1; inst_addr = 32'h1C000080;
        sample();
        chk1("t5o_inst_addr_ok", inst_addr_ok, 1'b1);
        iq.push_back(32'h55AA55AA);
        tick();
        inst_req = 1'b0;
        sample();
        chk1("t5o_bready", bready, 1'b1);
        chk1("t5o_arvalid", arvalid, 1'b1);
        tick();
        rvalid = 1'b1; rdata = 32'h55AA55AA; rid = 4'd0;
        tick();
        rvalid = 1'b0;
        sample();
        chk32("t5o_fetch_done", inst_ok_cnt, base_i + 1);
        chk32("t5o_write_pending", data_ok_cnt, base_d);
        bvalid = 1'b1;
        tick();
        bvalid = 1'b0;
        sample();
        chk32("t5o_write_done", data_ok_cnt, base_d + 1);

        // Reset while in R_DATA abandons the fetch
        tick();
        inst_req = 1'b1; inst_addr = 32'h1C0000C0; arready = 1'b1;
        sample();
        chk1("t6_addr_ok", inst_addr_ok, 1'b1);
        tick();
        inst_req = 1'b0;
        tick();
        sample();
        chk1("t6_rready", rready, 1'b1);
        base_i = inst_ok_cnt;
        resetn = 1'b0; rvalid = 1'b1; rdata = 32'hFFFFFFFF;
        tick();
        resetn = 1'b1; rvalid = 1'b0;
        inst_req = 1'b1; inst_addr = 32'h1C000100;
        sample();
        chk1("t6_arvalid", arvalid, 1'b0);
        chk1("t6_rready_low", rready, 1'b0);
        chk1("t6_no_data_ok", inst_data_ok, 1'b0);
        chk1("t6_new_addr_ok", inst_addr_ok, 1'b1);
        iq.push_back(32'h600D600D);
        tick();
        inst_req = 1'b0;
        tick();
        rvalid = 1'b1; rdata = 32'h600D600D; rid = 4'd0;
        tick();
        rvalid = 1'b0;
        tick();
        sample();
        chk32("t6_ok_count", inst_ok_cnt, base_i + 1);

        chk32("end_iq_empty", 32'(iq.size()), 32'd0);
        chk32("end_dq_empty", 32'(dq.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/cpu_axi_bridge.md
Name: cpu_axi_bridge

Overview:
- Arbitrates the instruction-fetch port and the data-memory port of the 5-stage CPU onto one AXI3 master interface.
- The IF and MEM/WB stages see a sram-like req/addr_ok/data_ok handshake.
- Internally the block sequences the AR/R and AW/W/B channels with one read FSM and one write FSM.
- Data-side requests have priority, and read-after-write ordering is enforced inside the bridge.

Parameters:
- INST_ID, 4'd0, ARID driven for instruction reads
- DATA_ID, 4'd1, ARID/AWID/WID driven for data accesses

Ports:
- clk  in  1  clock
- resetn  in  1  synchronous active-low reset
- inst_req  in  1  fetch request (always a read)
- inst_size  in  2  0=byte, 1=half, 2=word
- inst_addr  in  32  fetch address
- inst_addr_ok  out  1  fetch request accepted this cycle
- inst_data_ok  out  1  fetch data valid
- inst_rdata  out  32  fetch data
- data_req  in  1  data request
- data_wr  in  1  1=write, 0=read
- data_size  in  2  access size
- data_addr  in  32  data address
- data_wstrb  in  4  byte enables
- data_wdata  in  32  write data
- data_addr_ok  out  1  data request accepted this cycle
- data_data_ok  out  1  read data valid / write complete
- data_rdata  out  32  read data
- arid/araddr/arsize/arvalid  out  4/32/3/1  AR channel
- arready  in  1  AR channel ready
- rid/rdata/rvalid  in  4/32/1  R channel
- rready  out  1  R channel ready
- awid/awaddr/awsize/awvalid  out  4/32/3/1  AW channel
- awready  in  1  AW channel ready
- wid/wdata/wstrb/wvalid  out  4/32/4/1  W channel
- wready  in  1  W channel ready
- bvalid  in  1  B channel valid
- bready  out  1  B channel ready
- Constant AXI fields (len=0, burst=INCR, lock/cache/prot=0, wlast=1) are tied off at the top level, not in this block.

Behaviour:
- Reset: resetn sampled at posedge clk, active low.
  - All valid/ready outputs, addr_ok and data_ok are 0.
  - Both FSMs go to IDLE; all address/data registers are 0.
  - Reset mid-transaction abandons the transaction (the slave is reset together with the bridge); no data_ok is produced afterwards.
- Read FSM states and transitions:
  - R_IDLE: accept a read request and go to R_AR.
  - R_AR: arvalid=1 with registered araddr, arsize and arid. On arvalid&arready go to R_DATA.
  - R_DATA: rready=1. On rvalid&rready, latch rdata into inst_rdata or data_rdata according to the registered requester bit, go to R_IDLE, and pulse the matching data_ok the NEXT cycle.
- Write FSM states and transitions:
  - W_IDLE: accept a write request and go to W_REQ.
  - W_REQ: awvalid and wvalid are both asserted. Each drops independently on its own handshake (aw_done/w_done flags). When both are done, go to W_RESP.
  - W_RESP: bready=1. On bvalid go to W_IDLE and pulse data_data_ok the next cycle.
- arsize = {1'b0, size}; awsize the same.
- addr_ok is combinational, same cycle as acceptance. Acceptance rules:
  - Data read: data_req & ~data_wr & R_IDLE & W_IDLE.
  - Data write: data_req & data_wr & W_IDLE & R_IDLE.
  - Instruction read: inst_req & R_IDLE & ~(data read accepted this cycle).
- Priority: when inst_req and a data read are requested in the same R_IDLE cycle, data wins and inst_addr_ok=0. The instruction request must be held by the requester.
- Ordering: a data read is never issued while a write is outstanding, and vice versa (RAW/WAR safe). Instruction reads may overlap a data write.
- At most one read and one write are outstanding. data_ok pulses last exactly 1 cycle.
- rid is not checked; the requester is taken from the registered read-owner bit.
- arvalid/awvalid/wvalid stay high until their handshake. Their payload is stable while valid.
- Latency with ready slaves:
  - Read: addr_ok cycle 0, arvalid cycle 1, R handshake cycle ≥2, data_ok one cycle after the R handshake.
  - Write: data_ok one cycle after the B handshake.

Test Plan:
- Single fetch: inst_req addr 0x1C000000, arready=1, rvalid 2 cycles later with rdata 0x02800C0C → inst_addr_ok at cycle 0, araddr=0x1C000000 arid=0, inst_data_ok=1 with inst_rdata=0x02800C0C for exactly 1 cycle.
- Simultaneous requests: inst_req and data read 0x1C0800F0 in the same cycle → data_addr_ok=1, inst_addr_ok=0, first AR has arid=1; fetch issues after the data R handshake.
- Write then read same address: data write 0x1C080000 wstrb=0xF wdata=0xDEADBEEF, then data read 0x1C080000 → read addr_ok held 0 until bvalid accepted; read returns the slave's 0xDEADBEEF.
- Split AW/W: awready high at cycle 1, wready delayed to cycle 4 → awvalid drops after cycle 1, wvalid held through cycle 4, bready only after both, data_data_ok once.
- Backpressure and overlap: arready=0 for 5 cycles → arvalid/araddr stable. Issue a fetch during an outstanding data write → the fetch completes before bvalid.
- Reset in R_DATA: deassert resetn for 1 cycle → arvalid=rready=0, no data_ok, next inst_req accepted immediately.
